// File: rtl/ss_pkg.sv
// Shared definitions for the stream-transfer scheduler: channel count,
// channel index width and the scheduler state encoding.
package ss_pkg;

  localparam int SS_NCH = 4;
  localparam int SS_CHW = 2;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_XFER = 2'd1,
    SS_GAP  = 2'd2
  } ss_state_e;

endpackage

// File: rtl/ss_arb_rr_pick4.sv
// Combinational 4-way round-robin picker. Searches upward from last+1
// (wrapping mod 4) and returns the first requesting channel.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);
  import ss_pkg::*;

  logic [SS_CHW-1:0] idx;

  // Scan the four candidates in rotating priority order; first hit wins.
  always_comb begin
    pick = last;
    any  = 1'b0;
    idx  = last;
    for (int i = 1; i <= SS_NCH; i++) begin
      idx = last + SS_CHW'(i);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ss_arb.sv
// Round-robin scheduler sharing one stream-transfer engine between four
// channel FIFOs. A grant moves up to BURST_LEN beats, then a one-cycle GAP
// lets FIFO status settle before the next arbitration.
//
// Handshake: a beat transfers in any XFER cycle where the granted channel
// is enabled, its FIFO reports ss_readyN, and the engine reports eng_ready.
// In that same cycle ss_xferN (to the FIFO) and eng_xfer (to the engine)
// are driven high combinationally; each strobe means exactly one beat moved.
module ss_arb #(
  parameter int BURST_LEN = 16,
  parameter int CW        = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [3:0]    ch_en,
  input  logic          ss_ready0,
  input  logic          ss_ready1,
  input  logic          ss_ready2,
  input  logic          ss_ready3,
  input  logic          eng_ready,
  output logic          ss_xfer0,
  output logic          ss_xfer1,
  output logic          ss_xfer2,
  output logic          ss_xfer3,
  output logic          eng_xfer,
  output logic          gnt_valid,
  output logic [1:0]    gnt_ch,
  output logic [CW-1:0] xfer_cnt,
  output logic          burst_done,
  output logic [1:0]    dbg_state
);
  import ss_pkg::*;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  ss_state_e  state;
  logic [1:0] last;
  logic [3:0] ss_ready;
  logic [3:0] req;
  logic [3:0] ss_xfer;
  logic [1:0] pick;
  logic       pick_any;
  logic       gnt_live;
  logic       beat;

  assign ss_ready = {ss_ready3, ss_ready2, ss_ready1, ss_ready0};
  assign req      = ch_en & ss_ready;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (pick_any)
  );

  // The granted channel can still supply beats; losing this ends the grant.
  assign gnt_live = ss_ready[gnt_ch] & ch_en[gnt_ch];
  // Reset gating keeps strobes quiet in the cycle a reset is applied.
  assign beat     = wb_rst_i & (state == SS_XFER) & gnt_live & eng_ready;

  // Route the single beat strobe to the granted channel only.
  always_comb begin
    ss_xfer = '0;
    if (beat) ss_xfer[gnt_ch] = 1'b1;
  end

  assign {ss_xfer3, ss_xfer2, ss_xfer1, ss_xfer0} = ss_xfer;
  assign eng_xfer  = beat;
  assign dbg_state = state;

  // Scheduler FSM: arbitrate in IDLE, move beats in XFER, settle in GAP.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= SS_IDLE;
      last       <= 2'd3;
      gnt_ch     <= 2'd0;
      xfer_cnt   <= '0;
      gnt_valid  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      case (state)
        SS_IDLE: begin
          burst_done <= 1'b0;
          if (pick_any) begin
            gnt_ch    <= pick;
            xfer_cnt  <= '0;
            gnt_valid <= 1'b1;
            state     <= SS_XFER;
          end
        end
        SS_XFER: begin
          if (!gnt_live) begin
            // Channel dropped out: end the grant without a beat.
            gnt_valid  <= 1'b0;
            burst_done <= 1'b1;
            state      <= SS_GAP;
          end else if (beat) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_cnt == LAST_BEAT) begin
              gnt_valid  <= 1'b0;
              burst_done <= 1'b1;
              state      <= SS_GAP;
            end
          end
        end
        SS_GAP: begin
          burst_done <= 1'b0;
          last       <= gnt_ch;
          state      <= SS_IDLE;
        end
        default: begin
          gnt_valid  <= 1'b0;
          burst_done <= 1'b0;
          state      <= SS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_arb.sv
// Directed bench for ss_arb: a BURST_LEN=16 instance exercised through
// single-channel, rotation, stall, early-termination and reset scenarios,
// plus a BURST_LEN=1 instance checked for single-beat rotation.
module tb_ss_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] ch_en;
  logic [3:0] ss_ready;
  logic       eng_ready;
  logic [3:0] ss_xfer;
  logic       eng_xfer;
  logic       gnt_valid;
  logic [1:0] gnt_ch;
  logic [7:0] xfer_cnt;
  logic       burst_done;
  logic [1:0] dbg_state;

  logic       b_rst_n;
  logic [3:0] b_ch_en;
  logic [3:0] b_ss_ready;
  logic       b_eng_ready;
  logic [3:0] b_ss_xfer;
  logic       b_eng_xfer;
  logic       b_gnt_valid;
  logic [1:0] b_gnt_ch;
  logic [7:0] b_xfer_cnt;
  logic       b_burst_done;
  logic [1:0] b_dbg_state;

  ss_arb #(.BURST_LEN(16), .CW(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .ch_en      (ch_en),
    .ss_ready0  (ss_ready[0]),
    .ss_ready1  (ss_ready[1]),
    .ss_ready2  (ss_ready[2]),
    .ss_ready3  (ss_ready[3]),
    .eng_ready  (eng_ready),
    .ss_xfer0   (ss_xfer[0]),
    .ss_xfer1   (ss_xfer[1]),
    .ss_xfer2   (ss_xfer[2]),
    .ss_xfer3   (ss_xfer[3]),
    .eng_xfer   (eng_xfer),
    .gnt_valid  (gnt_valid),
    .gnt_ch     (gnt_ch),
    .xfer_cnt   (xfer_cnt),
    .burst_done (burst_done),
    .dbg_state  (dbg_state)
  );

  ss_arb #(.BURST_LEN(1), .CW(8)) dut_b1 (
    .wb_clk_i   (clk),
    .wb_rst_i   (b_rst_n),
    .ch_en      (b_ch_en),
    .ss_ready0  (b_ss_ready[0]),
    .ss_ready1  (b_ss_ready[1]),
    .ss_ready2  (b_ss_ready[2]),
    .ss_ready3  (b_ss_ready[3]),
    .eng_ready  (b_eng_ready),
    .ss_xfer0   (b_ss_xfer[0]),
    .ss_xfer1   (b_ss_xfer[1]),
    .ss_xfer2   (b_ss_xfer[2]),
    .ss_xfer3   (b_ss_xfer[3]),
    .eng_xfer   (b_eng_xfer),
    .gnt_valid  (b_gnt_valid),
    .gnt_ch     (b_gnt_ch),
    .xfer_cnt   (b_xfer_cnt),
    .burst_done (b_burst_done),
    .dbg_state  (b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Strobe invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    check("one_strobe", 32'($countones(ss_xfer) <= 1), 1);
    check("eng_is_or", eng_xfer, |ss_xfer);
    check("b_one_strobe", 32'($countones(b_ss_xfer) <= 1), 1);
    check("b_eng_is_or", b_eng_xfer, |b_ss_xfer);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant;
    int n;
    n = 0;
    while (!gnt_valid && n < 8) begin
      tick();
      n++;
    end
    check("grant_seen", gnt_valid, 1);
  endtask

  // Run one grant to its GAP cycle. Stall window is in cycles from the
  // first XFER cycle; drop_kind 1 drops ss_ready, 2 drops ch_en, at cycle drop_at.
  task automatic run_grant(input logic [1:0] exp_ch, input int exp_beats, input int exp_cycles,
                           input int stall_at, input int stall_len,
                           input int drop_at, input int drop_kind);
    int c;
    int beats;
    wait_grant();
    check("gnt_ch", gnt_ch, exp_ch);
    check("cnt_start", xfer_cnt, 0);
    c = 0;
    beats = 0;
    while (gnt_valid && c < 200) begin
      eng_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (c == drop_at) begin
        if (drop_kind == 1) ss_ready[exp_ch] = 1'b0;
        else ch_en[exp_ch] = 1'b0;
      end
      #1;
      if (eng_xfer) beats++;
      if (!eng_ready) begin
        check("stall_quiet", eng_xfer, 0);
        check("stall_hold", gnt_valid, 1);
      end
      if (c == drop_at) check("drop_nobeat", eng_xfer, 0);
      c++;
      tick();
    end
    eng_ready = 1'b1;
    check("xfer_cycles", c, exp_cycles);
    check("beats", beats, exp_beats);
    check("gap_done", burst_done, 1);
    check("gap_cnt", xfer_cnt, exp_beats);
    check("gap_state", dbg_state, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ch_en = 4'h0; ss_ready = 4'h0; eng_ready = 1'b0;
    b_rst_n = 1'b0; b_ch_en = 4'hf; b_ss_ready = 4'hf; b_eng_ready = 1'b1;
    tick();
    tick();
    check("rst_gnt_valid", gnt_valid, 0);
    check("rst_gnt_ch", gnt_ch, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_strobes", {eng_xfer, ss_xfer}, 0);
    check("rst_state", dbg_state, 0);

    // Single channel: full burst, then regrant two cycles after GAP.
    rst_n = 1'b1; ch_en = 4'b0001; ss_ready = 4'b0001; eng_ready = 1'b1;
    run_grant(2'd0, 16, 16, -1, 0, -1, 0);
    tick();
    check("idle_gnt_valid", gnt_valid, 0);
    check("idle_done_low", burst_done, 0);
    check("idle_cnt_hold", xfer_cnt, 16);
    tick();
    check("regrant_valid", gnt_valid, 1);
    check("regrant_ch", gnt_ch, 0);

    // All channels requesting: rotation 0,1,2,3,0.
    ch_en = 4'hf; ss_ready = 4'hf;
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) run_grant(exp_q.pop_front(), 16, 16, -1, 0, -1, 0);

    // Stall for 5 cycles mid-burst on channel 1.
    run_grant(2'd1, 16, 21, 3, 5, -1, 0);

    // Early termination by ss_ready2, then channel 3 next.
    run_grant(2'd2, 5, 6, -1, 0, 5, 1);
    ss_ready = 4'hf;
    run_grant(2'd3, 16, 16, -1, 0, -1, 0);
    run_grant(2'd0, 16, 16, -1, 0, -1, 0);
    run_grant(2'd1, 16, 16, -1, 0, -1, 0);

    // Early termination by ch_en[2], then channel 3 next.
    run_grant(2'd2, 5, 6, -1, 0, 5, 2);
    ch_en = 4'hf;
    run_grant(2'd3, 16, 16, -1, 0, -1, 0);
    run_grant(2'd0, 16, 16, -1, 0, -1, 0);

    // Reset pulse at beat 7 of a channel 1 burst.
    wait_grant();
    check("rb_ch", gnt_ch, 1);
    repeat (7) tick();
    check("rb_cnt7", xfer_cnt, 7);
    rst_n = 1'b0;
    #1;
    check("rb_no_strobe", {eng_xfer, ss_xfer}, 0);
    tick();
    check("rb_valid", gnt_valid, 0);
    check("rb_ch0", gnt_ch, 0);
    check("rb_cnt", xfer_cnt, 0);
    check("rb_done", burst_done, 0);
    check("rb_strobes", {eng_xfer, ss_xfer}, 0);
    check("rb_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();
    check("rb_regrant", gnt_valid, 1);
    check("rb_regrant_ch", gnt_ch, 0);
    check("rb_done_after", burst_done, 0);

    // BURST_LEN=1 instance: one beat per grant, burst_done every 3 cycles.
    b_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e_x;
      e_x = 4'b0001 << (k % 4);
      tick();
      check("b1_valid", b_gnt_valid, 1);
      check("b1_ch", b_gnt_ch, k % 4);
      check("b1_strobe", b_ss_xfer, e_x);
      tick();
      check("b1_done", b_burst_done, 1);
      check("b1_cnt", b_xfer_cnt, 1);
      check("b1_gap_valid", b_gnt_valid, 0);
      tick();
      check("b1_done_low", b_burst_done, 0);
      check("b1_idle", b_dbg_state, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ss_arb.md
# ss_arb

Round-robin scheduler that shares the single stream-transfer engine between the four DMA channel FIFOs. Each cycle it grants at most one channel and moves up to `BURST_LEN` beats from that channel to the engine with a one-beat strobe handshake. It then releases the engine and re-arbitrates. It sits between the per-channel FIFO status/strobe pins (`ss_readyN` / `ss_xferN`) and the shared engine datapath.

## Interface
Parameters:
- `BURST_LEN`, default 16: maximum beats per grant. Legal range is 1..255.
- `CW`, default 8: beat counter width. Must satisfy 2^CW > `BURST_LEN`.

Ports (name, direction, width, meaning):
- `wb_clk_i`, in, 1: clock. All logic is on the rising edge.
- `wb_rst_i`, in, 1: reset. Synchronous, active-low.
- `ch_en`, in, 4: channel enabled. Bit N is set while the channel's scatter-gather state is active.
- `ss_ready0`..`ss_ready3`, in, 1 each: channel FIFO has a beat available.
- `eng_ready`, in, 1: engine accepts a beat this cycle.
- `ss_xfer0`..`ss_xfer3`, out, 1 each: beat-taken strobe to the channel FIFO.
- `eng_xfer`, out, 1: beat-valid strobe to the engine.
- `gnt_valid`, out, 1: a channel currently holds the engine.
- `gnt_ch`, out, 2: index of the granted channel. Valid while `gnt_valid` is high.
- `xfer_cnt`, out, CW: beats moved in the current grant.
- `burst_done`, out, 1: one-cycle pulse after a grant ends.

## Operation
- Request vector: `req[N] = ch_en[N] & ss_readyN`.
- State machine, with states IDLE, XFER, GAP:
  - **IDLE**: if `req != 0`, register the grant to the first set bit searching upward from `last+1` (mod 4), clear `xfer_cnt`, and go to XFER. Otherwise stay in IDLE.
  - **XFER**: a beat occurs when `ss_ready[gnt] & ch_en[gnt] & eng_ready`.
    - On a beat: assert `ss_xfer[gnt]` and `eng_xfer` combinationally, and increment `xfer_cnt`.
    - Exit to GAP when any of these holds:
      - (a) a beat occurs with `xfer_cnt == BURST_LEN-1`;
      - (b) `ch_en[gnt]` is low;
      - (c) `ss_ready[gnt]` is low.
    - For (b) and (c), no beat occurs in the exit cycle.
    - `eng_ready` low alone only stalls; it never ends the grant.
  - **GAP**: `burst_done` is 1. Set `last <= gnt` and go to IDLE. This single cycle lets FIFO status settle.
- `gnt_valid` is 1 only in XFER. `gnt_ch` holds its value through GAP and IDLE.
- At most one `ss_xferN` is high in any cycle. `eng_xfer` equals the OR of all `ss_xferN`.
- `xfer_cnt` holds its final value through GAP and is cleared only on the next grant.

## Timing
- Reset (`wb_rst_i` = 0 at an edge) sets:
  - state to IDLE;
  - `last` to 3, so channel 0 has first priority;
  - `gnt_ch`, `xfer_cnt`, `gnt_valid`, `burst_done` to 0;
  - all strobes to 0.
- Reset asserted mid-burst aborts the burst at that edge. No `burst_done` pulse is generated and no strobe is issued in the reset cycle.
- Latency from `req` high in IDLE to the first possible `ss_xfer` is 1 cycle, at the XFER cycle after the grant edge.
- Minimum turnaround between grants is 2 cycles (GAP, then IDLE) with no beat. Back-to-back full bursts therefore sustain `BURST_LEN/(BURST_LEN+2)` beats per cycle.
- Strobes depend combinationally on `ss_readyN`, `ch_en` and `eng_ready`. All other outputs are registered.
- If `BURST_LEN` = 1: each grant moves exactly 1 beat, and exit (a) occurs on the first beat.
- Simultaneous requests are resolved purely by the round-robin order. A channel that just finished is lowest priority at the next arbitration.

## Structure
- Shared package (`ss_pkg`): the state encoding (IDLE=2'd0, XFER=2'd1, GAP=2'd2), the channel count constant `SS_NCH = 4`, and the channel index width 2.
- One sub-module, `rr_pick4`: a purely combinational 4-way round-robin picker. Inputs are `req[3:0]` and `last[1:0]`; outputs are `pick[1:0]` and `any`. The FSM, counter and strobe logic stay in `ss_arb`.

## Test plan
- **Single channel:** reset, then `ch_en=4'b0001`, `ss_ready0=1`, `eng_ready=1`, `BURST_LEN=16`.
  - Expect 16 consecutive `ss_xfer0`/`eng_xfer` pulses starting 1 cycle after grant, `xfer_cnt=16`, then a `burst_done` pulse.
  - Expect the next grant to channel 0 two cycles later.
- **All channels requesting:** `ch_en=4'b1111`, all `ss_ready` high.
  - Expect grant order 0,1,2,3,0, each burst 16 beats, with `gnt_ch` matching the order.
  - No cycle may have two strobes high.
- **Stall:** hold `eng_ready=0` for 5 cycles mid-burst.
  - Expect no strobes while `eng_ready` is low and `gnt_valid` to stay 1.
  - Expect the burst to resume and complete at 16 beats, with 21 XFER cycles in total.
- **Early termination:** drop `ss_ready2` after 5 beats.
  - Expect no beat in the drop cycle, GAP next with `burst_done=1` and `xfer_cnt=5`, and channel 3 granted next.
  - Repeat with `ch_en[2]` dropped instead of `ss_ready2`; expect the same result.
- **Reset mid-burst:** pulse `wb_rst_i` low for 1 cycle at beat 7 of a channel 1 burst.
  - Expect all outputs 0 at the next edge and no `burst_done` pulse.
  - Expect the next grant to go to channel 0 even if channel 1 is still requesting.
- **`BURST_LEN=1` build:** all four channels requesting.
  - Expect exactly one beat per grant in rotating order 0,1,2,3, and `burst_done` every 3 cycles.
